// File: rtl/fpu_ss_pkg.sv
// Shared types and constants for the core-side FPU subsystem offload path.
// Request/response payloads and the operand field positions of the instruction word.
package fpu_ss_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned NUM_RS     = 3;

    typedef struct packed {
        logic [NUM_RS-1:0][XLEN-1:0] rs;
        logic [XLEN-1:0]             instr_data;
    } offload_req_t;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [4:0]      rd;
        logic            error;
    } offload_rsp_t;

    // LSB of the rs1/rs2/rs3 register fields (rs3 lives in the R4-type funct5 slot).
    function automatic int unsigned rs_lsb(input int unsigned idx);
        case (idx)
            0:       return 15;
            1:       return 20;
            default: return 27;
        endcase
    endfunction

endpackage

// File: rtl/fpu_ss_scoreboard.sv
// Integer-destination pending vector: one bit per register, x0 never pending.
// Set and clear of different bits in the same cycle both take effect.
module fpu_ss_scoreboard
    import fpu_ss_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_set_en,
    input  logic [4:0]             i_set_addr,
    input  logic                   i_clr_en,
    input  logic [4:0]             i_clr_addr,
    input  logic [NUM_RS-1:0][4:0] i_rs_addr,
    output logic [NUM_RS-1:0]      o_rs_pending,
    input  logic [4:0]             i_rd_addr,
    output logic                   o_rd_pending,
    output logic [31:0]            o_pending
);

    logic [31:1] r_pending;
    logic [31:1] w_set_mask;
    logic [31:1] w_clr_mask;
    logic [31:0] w_pending;

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_mask
            assign w_set_mask[gi] = i_set_en && (i_set_addr == 5'(gi));
            assign w_clr_mask[gi] = i_clr_en && (i_clr_addr == 5'(gi));
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
        end
    end

    assign w_pending = {r_pending, 1'b0};

    generate
        for (genvar gi = 0; gi < NUM_RS; gi++) begin : g_rd_port
            assign o_rs_pending[gi] = w_pending[i_rs_addr[gi]];
        end
    endgenerate

    assign o_rd_pending = w_pending[i_rd_addr];
    assign o_pending    = w_pending;

endmodule

// File: rtl/fpu_ss_offload_unit.sv
// Offload stage between the core predecoder and the FPU subsystem C-request/C-response channels.
// Tracks integer destinations in flight so dependent core instructions stall until writeback.
module fpu_ss_offload_unit
    import fpu_ss_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter logic [31:0] HART_ID         = 32'd0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         instr_valid_i,
    output logic                         instr_ready_o,
    input  logic [31:0]                  instr_i,
    input  logic [NUM_RS-1:0][XLEN-1:0]  rs_i,
    input  logic [NUM_RS-1:0]            rs_used_i,
    input  logic                         rsp_expected_i,
    output logic                         c_q_valid_o,
    input  logic                         c_q_ready_i,
    output logic [ADDR_WIDTH-1:0]        c_q_addr_o,
    output logic [NUM_RS-1:0][XLEN-1:0]  c_q_rs_o,
    output logic [31:0]                  c_q_instr_data_o,
    output logic [31:0]                  c_q_hart_id_o,
    input  logic                         c_p_valid_i,
    output logic                         c_p_ready_o,
    input  logic [31:0]                  c_p_data_i,
    input  logic [4:0]                   c_p_rd_i,
    input  logic                         c_p_error_i,
    input  logic                         c_p_dualwb_i,
    output logic                         wb_valid_o,
    input  logic                         wb_ready_i,
    output logic [4:0]                   wb_addr_o,
    output logic [31:0]                  wb_data_o,
    output logic                         err_o,
    output logic [4:0]                   err_rd_o,
    output logic                         busy_o,
    input  logic [NUM_RS-1:0][4:0]       stall_rs_i,
    output logic                         stall_o
);

    localparam int unsigned      CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic             r_req_full;
    offload_req_t     r_req;
    logic             r_resp_full;
    offload_rsp_t     r_resp;
    logic [CNT_W-1:0] r_outstanding;

    logic [NUM_RS-1:0][4:0] w_rs_addr;
    logic [NUM_RS-1:0]      w_rs_pending;
    logic [NUM_RS-1:0]      w_rs_hazard;
    logic [NUM_RS-1:0]      w_query_hit;
    logic [4:0]             w_rd;
    logic                   w_rd_pending;
    logic [31:0]            w_pending;
    logic                   w_req_drain;
    logic                   w_req_slot_free;
    logic                   w_rsp_ok;
    logic                   w_accept;
    logic                   w_cp_hs;
    logic                   w_retire;
    logic                   w_cnt_inc;
    logic                   w_cnt_dec;
    logic                   w_unused_dualwb;

    assign w_unused_dualwb = c_p_dualwb_i;
    assign w_rd            = instr_i[11:7];

    generate
        for (genvar gi = 0; gi < NUM_RS; gi++) begin : g_rs
            assign w_rs_addr[gi]   = instr_i[rs_lsb(gi) +: 5];
            assign w_rs_hazard[gi] = rs_used_i[gi] && w_rs_pending[gi];
            // x0 is never pending, so a zero query address can never hit.
            assign w_query_hit[gi] = w_pending[stall_rs_i[gi]];
        end
    endgenerate

    // Request slot may be refilled in the same cycle it hands off, sustaining one offload per cycle.
    assign w_req_drain     = r_req_full && c_q_ready_i;
    assign w_req_slot_free = !r_req_full || w_req_drain;
    assign w_rsp_ok        = !rsp_expected_i || (!w_rd_pending && (r_outstanding < MAX_CNT));
    assign instr_ready_o   = w_req_slot_free && !(|w_rs_hazard) && w_rsp_ok;
    assign w_accept        = instr_valid_i && instr_ready_o;

    // Errors and x0 results need no RF port, so they retire without waiting for wb_ready_i.
    assign w_retire    = r_resp_full && (r_resp.error || (r_resp.rd == 5'd0) || wb_ready_i);
    assign c_p_ready_o = !r_resp_full || w_retire;
    assign w_cp_hs     = c_p_valid_i && c_p_ready_o;

    assign w_cnt_inc = w_accept && rsp_expected_i;
    assign w_cnt_dec = w_retire && (r_outstanding != '0);

    fpu_ss_scoreboard u_scoreboard (
        .i_clk        (clk_i),
        .i_rst_n      (rst_ni),
        .i_set_en     (w_cnt_inc),
        .i_set_addr   (w_rd),
        .i_clr_en     (w_retire),
        .i_clr_addr   (r_resp.rd),
        .i_rs_addr    (w_rs_addr),
        .o_rs_pending (w_rs_pending),
        .i_rd_addr    (w_rd),
        .o_rd_pending (w_rd_pending),
        .o_pending    (w_pending)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_req_full <= 1'b0;
            r_req      <= '0;
        end else if (w_accept) begin
            r_req_full <= 1'b1;
            r_req      <= '{rs: rs_i, instr_data: instr_i};
        end else if (w_req_drain) begin
            r_req_full <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_resp_full <= 1'b0;
            r_resp      <= '0;
        end else if (w_cp_hs) begin
            r_resp_full <= 1'b1;
            r_resp      <= '{data: c_p_data_i, rd: c_p_rd_i, error: c_p_error_i};
        end else if (w_retire) begin
            r_resp_full <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_outstanding <= '0;
        end else begin
            case ({w_cnt_inc, w_cnt_dec})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign c_q_valid_o      = r_req_full;
    assign c_q_addr_o       = '0;
    assign c_q_rs_o         = r_req.rs;
    assign c_q_instr_data_o = r_req.instr_data;
    assign c_q_hart_id_o    = HART_ID;

    assign wb_valid_o = r_resp_full && !r_resp.error && (r_resp.rd != 5'd0);
    assign wb_addr_o  = r_resp.rd;
    assign wb_data_o  = r_resp.data;
    assign err_o      = r_resp_full && r_resp.error;
    assign err_rd_o   = err_o ? r_resp.rd : 5'd0;

    assign busy_o  = r_req_full || r_resp_full || (r_outstanding != '0);
    assign stall_o = |w_query_hit;

    // A response nobody is waiting for means the accelerator broke the protocol.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (c_p_valid_i && c_p_ready_o) |-> (r_outstanding != '0));

endmodule

// File: tb/tb_fpu_ss_offload_unit.sv
// Self-checking bench for fpu_ss_offload_unit: directed scenarios plus a randomized run
// against a transaction-level model of the offload/writeback rules.
`timescale 1ns/1ps
module tb_fpu_ss_offload_unit;

    localparam int MAXO = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              instr_valid_i;
    logic              instr_ready_o;
    logic [31:0]       instr_i;
    logic [2:0][31:0]  rs_i;
    logic [2:0]        rs_used_i;
    logic              rsp_expected_i;
    logic              c_q_valid_o;
    logic              c_q_ready_i;
    logic [fpu_ss_pkg::ADDR_WIDTH-1:0] c_q_addr_o;
    logic [2:0][31:0]  c_q_rs_o;
    logic [31:0]       c_q_instr_data_o;
    logic [31:0]       c_q_hart_id_o;
    logic              c_p_valid_i;
    logic              c_p_ready_o;
    logic [31:0]       c_p_data_i;
    logic [4:0]        c_p_rd_i;
    logic              c_p_error_i;
    logic              c_p_dualwb_i;
    logic              wb_valid_o;
    logic              wb_ready_i;
    logic [4:0]        wb_addr_o;
    logic [31:0]       wb_data_o;
    logic              err_o;
    logic [4:0]        err_rd_o;
    logic              busy_o;
    logic [2:0][4:0]   stall_rs_i;
    logic              stall_o;

    int checks = 0;
    int failures = 0;

    // Reference model state for the randomized run
    bit              pend [32];
    int              m_out;
    bit              m_req_full, m_req_rsp;
    logic [31:0]     m_req_instr;
    logic [2:0][31:0] m_req_rs;
    bit              m_resp_full, m_resp_err;
    logic [4:0]      m_resp_rd;
    logic [31:0]     m_resp_data;
    logic [4:0]      await_q [$];

    always #5 clk = ~clk;

    fpu_ss_offload_unit #(.MAX_OUTSTANDING(MAXO), .HART_ID(32'd0)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .instr_i(instr_i),
        .rs_i(rs_i), .rs_used_i(rs_used_i), .rsp_expected_i(rsp_expected_i),
        .c_q_valid_o(c_q_valid_o), .c_q_ready_i(c_q_ready_i), .c_q_addr_o(c_q_addr_o),
        .c_q_rs_o(c_q_rs_o), .c_q_instr_data_o(c_q_instr_data_o), .c_q_hart_id_o(c_q_hart_id_o),
        .c_p_valid_i(c_p_valid_i), .c_p_ready_o(c_p_ready_o), .c_p_data_i(c_p_data_i),
        .c_p_rd_i(c_p_rd_i), .c_p_error_i(c_p_error_i), .c_p_dualwb_i(c_p_dualwb_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
        .err_o(err_o), .err_rd_o(err_rd_o), .busy_o(busy_o),
        .stall_rs_i(stall_rs_i), .stall_o(stall_o)
    );

    function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [4:0] rs3);
        logic [31:0] w;
        w = $urandom;
        w[11:7] = rd; w[19:15] = rs1; w[24:20] = rs2; w[31:27] = rs3;
        return w;
    endfunction

    task automatic idle();
        instr_valid_i = 0; instr_i = '0; rs_i = '0; rs_used_i = '0; rsp_expected_i = 0;
        c_q_ready_i = 0; c_p_valid_i = 0; c_p_data_i = '0; c_p_rd_i = '0; c_p_error_i = 0;
        c_p_dualwb_i = 0; wb_ready_i = 0; stall_rs_i = '0;
    endtask

    task automatic drive_instr(input logic [31:0] w, input bit rsp, input logic [2:0] used);
        instr_valid_i = 1; instr_i = w; rsp_expected_i = rsp; rs_used_i = used;
        rs_i = {$urandom, $urandom, $urandom};
    endtask

    task automatic apply_reset();
        @(negedge clk); idle(); rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk); #1;
        checks++;
        if ({instr_ready_o, c_q_valid_o, c_p_ready_o, wb_valid_o, err_o, busy_o, stall_o} !== 7'b1010000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=1010000",
                     {instr_ready_o, c_q_valid_o, c_p_ready_o, wb_valid_o, err_o, busy_o, stall_o});
        end
        checks++;
        if ({wb_data_o, wb_addr_o, err_rd_o, c_q_instr_data_o, c_q_hart_id_o, c_q_addr_o} !== '0) begin
            failures++;
            $display("FAIL reset_data got wb_data=%h wb_addr=%0d err_rd=%0d instr=%h hart=%h exp all zero",
                     wb_data_o, wb_addr_o, err_rd_o, c_q_instr_data_o, c_q_hart_id_o);
        end
    endtask

    task automatic test_single();
        logic [31:0] w;
        logic [2:0][31:0] rs;
        @(negedge clk); c_q_ready_i = 1;
        w = mk(5'd5, 5'd0, 5'd0, 5'd0);
        drive_instr(w, 1, 3'b000); rs = rs_i; #1;
        checks++;
        if (instr_ready_o !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", instr_ready_o); end
        @(negedge clk); instr_valid_i = 0; stall_rs_i[0] = 5'd5; #1;
        checks++;
        if ({c_q_valid_o, c_q_instr_data_o, c_q_rs_o} !== {1'b1, w, rs}) begin
            failures++; $display("FAIL single_cq got v=%b instr=%h exp v=1 instr=%h", c_q_valid_o, c_q_instr_data_o, w);
        end
        checks++;
        if ({stall_o, busy_o} !== 2'b11) begin failures++; $display("FAIL single_stall got=%b exp=11", {stall_o, busy_o}); end
        @(negedge clk);
        c_p_valid_i = 1; c_p_rd_i = 5'd5; c_p_data_i = 32'h3F800000; c_p_error_i = 0; #1;
        checks++;
        if ({c_q_valid_o, c_p_ready_o} !== 2'b01) begin
            failures++; $display("FAIL single_cp_ready got=%b exp=01", {c_q_valid_o, c_p_ready_o});
        end
        @(negedge clk); c_p_valid_i = 0; wb_ready_i = 1; #1;
        checks++;
        if ({wb_valid_o, wb_addr_o, wb_data_o, stall_o} !== {1'b1, 5'd5, 32'h3F800000, 1'b1}) begin
            failures++; $display("FAIL single_wb got v=%b addr=%0d data=%h stall=%b exp v=1 addr=5 data=3f800000 stall=1",
                                 wb_valid_o, wb_addr_o, wb_data_o, stall_o);
        end
        $display("txn single wb rd=%0d data=%h", wb_addr_o, wb_data_o);
        @(negedge clk); #1;
        checks++;
        if ({wb_valid_o, stall_o, busy_o} !== 3'b000) begin
            failures++; $display("FAIL single_after got=%b exp=000", {wb_valid_o, stall_o, busy_o});
        end
        idle();
    endtask

    task automatic test_dependent();
        logic [31:0] dep;
        @(negedge clk); c_q_ready_i = 1;
        drive_instr(mk(5'd5, 5'd0, 5'd0, 5'd0), 1, 3'b000);
        @(negedge clk);
        dep = mk(5'd9, 5'd5, 5'd0, 5'd0);
        drive_instr(dep, 0, 3'b001); #1;
        checks++;
        if (instr_ready_o !== 1'b0) begin failures++; $display("FAIL dep_block0 got=%b exp=0", instr_ready_o); end
        @(negedge clk); c_p_valid_i = 1; c_p_rd_i = 5'd5; c_p_data_i = $urandom; #1;
        checks++;
        if (instr_ready_o !== 1'b0) begin failures++; $display("FAIL dep_block1 got=%b exp=0", instr_ready_o); end
        @(negedge clk); c_p_valid_i = 0; wb_ready_i = 1; #1;
        checks++;
        if ({instr_ready_o, wb_valid_o} !== 2'b01) begin
            failures++; $display("FAIL dep_block_wb got=%b exp=01", {instr_ready_o, wb_valid_o});
        end
        @(negedge clk); #1;
        checks++;
        if (instr_ready_o !== 1'b1) begin failures++; $display("FAIL dep_release got=%b exp=1", instr_ready_o); end
        @(negedge clk); instr_valid_i = 0; #1;
        checks++;
        if ({c_q_valid_o, c_q_instr_data_o} !== {1'b1, dep}) begin
            failures++; $display("FAIL dep_cq got v=%b instr=%h exp v=1 instr=%h", c_q_valid_o, c_q_instr_data_o, dep);
        end
        $display("txn dependent issued instr=%h", c_q_instr_data_o);
        @(negedge clk); idle();
    endtask

    task automatic test_max_outstanding();
        @(negedge clk); c_q_ready_i = 1;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge clk);
            drive_instr(mk(5'(k), 5'd0, 5'd0, 5'd0), 1, 3'b000); #1;
            checks++;
            if (instr_ready_o !== 1'b1) begin failures++; $display("FAIL max_fill%0d got=%b exp=1", k, instr_ready_o); end
        end
        @(negedge clk); drive_instr(mk(5'd5, 5'd0, 5'd0, 5'd0), 1, 3'b000); #1;
        checks++;
        if (instr_ready_o !== 1'b0) begin failures++; $display("FAIL max_block got=%b exp=0", instr_ready_o); end
        c_p_valid_i = 1; c_p_rd_i = 5'd1; c_p_data_i = $urandom; c_p_error_i = 0;
        @(negedge clk); c_p_valid_i = 0; wb_ready_i = 1; #1;
        checks++;
        if ({instr_ready_o, wb_valid_o, wb_addr_o} !== {1'b0, 1'b1, 5'd1}) begin
            failures++; $display("FAIL max_wb got ready=%b v=%b addr=%0d exp ready=0 v=1 addr=1", instr_ready_o, wb_valid_o, wb_addr_o);
        end
        @(negedge clk); #1;
        checks++;
        if (instr_ready_o !== 1'b1) begin failures++; $display("FAIL max_unblock got=%b exp=1", instr_ready_o); end
        @(negedge clk); instr_valid_i = 0;
        for (int k = 2; k <= 5; k++) begin
            c_p_valid_i = 1; c_p_rd_i = 5'(k); c_p_data_i = 32'(k * 32'h1111);
            @(negedge clk); #1;
            checks++;
            if ({wb_valid_o, wb_addr_o, wb_data_o} !== {1'b1, 5'(k), 32'(k * 32'h1111)}) begin
                failures++; $display("FAIL max_drain%0d got v=%b addr=%0d data=%h", k, wb_valid_o, wb_addr_o, wb_data_o);
            end
            $display("txn drain wb rd=%0d data=%h", wb_addr_o, wb_data_o);
        end
        c_p_valid_i = 0;
        @(negedge clk); #1;
        checks++;
        if ({wb_valid_o, busy_o} !== 2'b00) begin failures++; $display("FAIL max_idle got=%b exp=00", {wb_valid_o, busy_o}); end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] first;
        logic [31:0] seq [4];
        @(negedge clk); c_q_ready_i = 0;
        first = mk(5'd0, 5'd0, 5'd0, 5'd0);
        drive_instr(first, 0, 3'b000);
        for (int k = 0; k < 4; k++) seq[k] = mk(5'd0, 5'(k + 1), 5'd0, 5'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); drive_instr(seq[0], 0, 3'b000); #1;
            checks++;
            if ({instr_ready_o, c_q_valid_o, c_q_instr_data_o} !== {1'b0, 1'b1, first}) begin
                failures++; $display("FAIL bp_hold%0d got ready=%b v=%b instr=%h exp ready=0 v=1 instr=%h",
                                     c, instr_ready_o, c_q_valid_o, c_q_instr_data_o, first);
            end
        end
        c_q_ready_i = 1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            drive_instr(seq[k], 0, 3'b000); #1;
            checks++;
            if ({instr_ready_o, c_q_valid_o, c_q_instr_data_o} !== {1'b1, 1'b1, (k == 0) ? first : seq[k-1]}) begin
                failures++; $display("FAIL b2b%0d got ready=%b v=%b instr=%h", k, instr_ready_o, c_q_valid_o, c_q_instr_data_o);
            end
            $display("txn b2b accept %0d instr=%h", k, seq[k]);
        end
        @(negedge clk); instr_valid_i = 0; #1;
        checks++;
        if ({c_q_valid_o, c_q_instr_data_o} !== {1'b1, seq[3]}) begin
            failures++; $display("FAIL b2b_last got v=%b instr=%h exp v=1 instr=%h", c_q_valid_o, c_q_instr_data_o, seq[3]);
        end
        @(negedge clk); #1;
        checks++;
        if ({c_q_valid_o, busy_o} !== 2'b00) begin failures++; $display("FAIL b2b_empty got=%b exp=00", {c_q_valid_o, busy_o}); end
        idle();
    endtask

    task automatic test_error();
        @(negedge clk); c_q_ready_i = 1;
        drive_instr(mk(5'd7, 5'd0, 5'd0, 5'd0), 1, 3'b000);
        @(negedge clk); instr_valid_i = 0;
        @(negedge clk); c_p_valid_i = 1; c_p_rd_i = 5'd7; c_p_error_i = 1; c_p_data_i = $urandom;
        @(negedge clk); c_p_valid_i = 0; c_p_error_i = 0; wb_ready_i = 0; stall_rs_i[1] = 5'd7; #1;
        checks++;
        if ({err_o, err_rd_o, wb_valid_o} !== {1'b1, 5'd7, 1'b0}) begin
            failures++; $display("FAIL err_pulse got err=%b rd=%0d wbv=%b exp err=1 rd=7 wbv=0", err_o, err_rd_o, wb_valid_o);
        end
        $display("txn error rd=%0d", err_rd_o);
        @(negedge clk); #1;
        checks++;
        if ({err_o, wb_valid_o, busy_o, stall_o} !== 4'b0000) begin
            failures++; $display("FAIL err_after got=%b exp=0000", {err_o, wb_valid_o, busy_o, stall_o});
        end
        idle();
    endtask

    task automatic test_reset_mid();
        @(negedge clk); c_q_ready_i = 1;
        drive_instr(mk(5'd3, 5'd0, 5'd0, 5'd0), 1, 3'b000);
        @(negedge clk); drive_instr(mk(5'd4, 5'd0, 5'd0, 5'd0), 1, 3'b000);
        @(negedge clk); instr_valid_i = 0; c_p_valid_i = 1; c_p_rd_i = 5'd3; c_p_data_i = $urandom;
        @(negedge clk); c_p_valid_i = 0; stall_rs_i[0] = 5'd4; stall_rs_i[1] = 5'd3; #1;
        checks++;
        if ({wb_valid_o, busy_o, stall_o} !== 3'b111) begin
            failures++; $display("FAIL rmid_pre got=%b exp=111", {wb_valid_o, busy_o, stall_o});
        end
        #2 rst_n = 0; #1;
        checks++;
        if ({c_q_valid_o, wb_valid_o, err_o, busy_o, stall_o, c_p_ready_o, instr_ready_o} !== 7'b0000011 ||
            wb_data_o !== '0) begin
            failures++; $display("FAIL rmid_async got=%b data=%h exp=0000011 data=0",
                                 {c_q_valid_o, wb_valid_o, err_o, busy_o, stall_o, c_p_ready_o, instr_ready_o}, wb_data_o);
        end
        @(negedge clk); rst_n = 1;
        @(negedge clk); #1;
        checks++;
        if ({wb_valid_o, err_o, busy_o, stall_o} !== 4'b0000) begin
            failures++; $display("FAIL rmid_after got=%b exp=0000", {wb_valid_o, err_o, busy_o, stall_o});
        end
        idle();
    endtask

    task automatic test_random();
        logic [4:0]  rdv, r1, r2, r3;
        logic [4:0]  rs_addr [3];
        int          pick;
        bit          hazard, exp_ready, exp_stall, exp_retire, exp_cpr, exp_wbv, exp_err, exp_busy;
        bit          acc, cqhs, cphs;
        apply_reset();
        foreach (pend[i]) pend[i] = 0;
        m_out = 0; m_req_full = 0; m_req_rsp = 0; m_resp_full = 0; m_resp_err = 0;
        m_resp_rd = '0; m_resp_data = '0; m_req_instr = '0; m_req_rs = '0;
        await_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rdv = 5'($urandom_range(0, 7)); r1 = 5'($urandom_range(0, 7));
            r2 = 5'($urandom_range(0, 7));  r3 = 5'($urandom_range(0, 7));
            rs_addr[0] = r1; rs_addr[1] = r2; rs_addr[2] = r3;
            drive_instr(mk(rdv, r1, r2, r3), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            instr_valid_i = 1'($urandom_range(0, 1));
            c_q_ready_i = ($urandom_range(0, 3) != 0);
            wb_ready_i = 1'($urandom_range(0, 1));
            for (int j = 0; j < 3; j++) stall_rs_i[j] = 5'($urandom_range(0, 7));
            c_p_data_i = $urandom; c_p_error_i = ($urandom_range(0, 7) == 0); c_p_dualwb_i = 1'($urandom_range(0, 1));
            pick = 0; c_p_valid_i = 0; c_p_rd_i = '0;
            if (await_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                pick = $urandom_range(0, await_q.size() - 1);
                c_p_valid_i = 1; c_p_rd_i = await_q[pick];
            end
            #1;
            hazard = 0;
            for (int j = 0; j < 3; j++) if (rs_used_i[j] && pend[rs_addr[j]]) hazard = 1;
            exp_ready = (!m_req_full || c_q_ready_i) && !hazard &&
                        (!rsp_expected_i || (!pend[rdv] && m_out < MAXO));
            exp_stall = 0;
            for (int j = 0; j < 3; j++) if (pend[stall_rs_i[j]]) exp_stall = 1;
            exp_retire = m_resp_full && (m_resp_err || m_resp_rd == 0 || wb_ready_i);
            exp_cpr  = !m_resp_full || exp_retire;
            exp_wbv  = m_resp_full && !m_resp_err && m_resp_rd != 0;
            exp_err  = m_resp_full && m_resp_err;
            exp_busy = m_req_full || m_resp_full || m_out != 0;
            checks++;
            if ({instr_ready_o, stall_o, c_p_ready_o, wb_valid_o, err_o, busy_o, c_q_valid_o} !==
                {exp_ready, exp_stall, exp_cpr, exp_wbv, exp_err, exp_busy, m_req_full}) begin
                failures++; $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", cyc,
                    {instr_ready_o, stall_o, c_p_ready_o, wb_valid_o, err_o, busy_o, c_q_valid_o},
                    {exp_ready, exp_stall, exp_cpr, exp_wbv, exp_err, exp_busy, m_req_full});
            end
            if (m_req_full) begin
                checks++;
                if ({c_q_instr_data_o, c_q_rs_o} !== {m_req_instr, m_req_rs}) begin
                    failures++; $display("FAIL rnd_cq cyc=%0d got instr=%h exp instr=%h", cyc, c_q_instr_data_o, m_req_instr);
                end
            end
            if (exp_wbv) begin
                checks++;
                if ({wb_addr_o, wb_data_o} !== {m_resp_rd, m_resp_data}) begin
                    failures++; $display("FAIL rnd_wb cyc=%0d got rd=%0d data=%h exp rd=%0d data=%h",
                                         cyc, wb_addr_o, wb_data_o, m_resp_rd, m_resp_data);
                end
            end
            if (exp_err) begin
                checks++;
                if (err_rd_o !== m_resp_rd) begin
                    failures++; $display("FAIL rnd_err_rd cyc=%0d got=%0d exp=%0d", cyc, err_rd_o, m_resp_rd);
                end
            end
            acc  = instr_valid_i && exp_ready;
            cqhs = m_req_full && c_q_ready_i;
            cphs = c_p_valid_i && exp_cpr;
            if (cqhs) $display("txn rnd cq instr=%h", m_req_instr);
            if (exp_retire) $display("txn rnd retire rd=%0d err=%0b", m_resp_rd, m_resp_err);
            @(posedge clk);
            if (exp_retire) begin
                if (m_out > 0) m_out--;
                pend[m_resp_rd] = 0;
                m_resp_full = 0;
            end
            if (cphs) begin
                await_q.delete(pick);
                m_resp_full = 1; m_resp_rd = c_p_rd_i; m_resp_data = c_p_data_i; m_resp_err = c_p_error_i;
            end
            if (cqhs) begin
                if (m_req_rsp) await_q.push_back(m_req_instr[11:7]);
                m_req_full = 0;
            end
            if (acc) begin
                m_req_full = 1; m_req_instr = instr_i; m_req_rs = rs_i; m_req_rsp = rsp_expected_i;
                if (rsp_expected_i) begin
                    m_out++;
                    if (rdv != 0) pend[rdv] = 1;
                end
            end
        end
        @(negedge clk); idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_single();
        test_dependent();
        test_max_outstanding();
        test_back_to_back();
        test_error();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_ss_offload_unit.md
# fpu_ss_offload_unit

Core-side offload stage sitting directly upstream of the FPU subsystem. Accepts instructions from the core's predecoder together with their integer operands and drives them onto the C-request channel. Consumes the C-response channel and writes integer results back to the core register file. Holds an integer-destination scoreboard and an outstanding-response counter so dependent core instructions stall until results return.

## Interface
- MAX_OUTSTANDING, 4, maximum offloaded instructions awaiting a response (≥1)
- HART_ID, 0, constant driven on c_q_hart_id_o
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- instr_valid_i / instr_ready_o  in/out  1  core offload handshake
- instr_i  in  32  instruction word
- rs_i  in  3x32  integer operands rs1..rs3
- rs_used_i  in  3  operand i read from integer RF
- rsp_expected_i  in  1  instruction produces a C-response (integer rd)
- c_q_valid_o / c_q_ready_i  out/in  1  C-request handshake
- c_q_addr_o  out  acc_pkg::AddrWidth  accelerator address (0)
- c_q_rs_o  out  3x32  operands; c_q_instr_data_o out 32; c_q_hart_id_o out 32
- c_p_valid_i / c_p_ready_o  in/out  1  C-response handshake
- c_p_data_i in 32; c_p_rd_i in 5; c_p_error_i in 1; c_p_dualwb_i in 1 (ignored)
- wb_valid_o / wb_ready_i  out/in  1  integer RF write port handshake
- wb_addr_o out 5; wb_data_o out 32
- err_o out 1 one-cycle error pulse; err_rd_o out 5
- busy_o out 1 high while any request or response is in flight
- stall_rs_i in 3x5; stall_o out 1: core hazard query, high if any queried nonzero address is pending

## Operation
- rd = instr_i[11:7]; rs1/rs2/rs3 = [19:15]/[24:20]/[31:27].
- Accept (instr_valid_i && instr_ready_o) requires: request register empty or draining this cycle; no used rs with scoreboard bit set; if rsp_expected_i, scoreboard[rd] clear (WAW) and outstanding < MAX_OUTSTANDING.
- On accept: load request register; if rsp_expected_i, outstanding+1 and set scoreboard[rd] (unless rd=0).
- Response register: loads on c_p handshake; c_p_ready_o = !resp_full || retiring.
- Non-error entry: wb_valid_o high, retires on wb_ready_i; clears scoreboard[rd], outstanding−1. rd=0: retired without wb_valid_o.
- Error entry: no writeback; err_o=1, err_rd_o=rd for exactly that cycle; retires unconditionally, clears scoreboard bit, decrements counter.
- Same-cycle set and clear of different bits both apply; counter +1/−1 together leaves it unchanged. Same-bit set+clear impossible (WAW stall).
- Counter width $clog2(MAX_OUTSTANDING+1); never over/underflows; response with outstanding=0 is a protocol error (assertion).
- busy_o = req_full || resp_full || outstanding≠0.

## Timing
- Reset: all valids/readies low except c_p_ready_o high and instr_ready_o combinational; scoreboard 0, counter 0, err_o 0, data outputs 0.
- Accept cycle N → c_q_valid_o from N+1; payload stable until c_q_ready_i.
- Back-to-back: new accept allowed in same cycle as c_q handshake → one request per cycle sustained.
- c_p handshake cycle M → wb_valid_o (or err_o) at M+1; earliest scoreboard clear at end of M+1.
- instr_ready_o and stall_o are combinational from registered state and inputs; no combinational path c_q_ready_i→c_q_valid_o.
- Reset mid-operation discards all in-flight state; no pulse after deassertion.

## Structure
- fpu_ss_pkg: offload_req_t {rs, instr_data} and offload_rsp_t {data, rd, error}.
- Sub-module fpu_ss_scoreboard: 32-bit pending vector, set/clear ports, 3 read ports + rd check; bit 0 hardwired 0.
- Counter, request register and response register in top module.

## Test plan
- Single offload, rsp_expected=1, rd=5, c_q_ready=1; response data 0x3F800000 → wb_valid_o one cycle later, wb_addr_o=5, scoreboard[5] cleared after wb_ready.
- Dependent instr with rs1=5 while rd 5 pending → instr_ready_o=0 until cycle after writeback, then accepted.
- MAX_OUTSTANDING=4: issue 5 rsp_expected instrs to rd 1..5 with no responses → fifth stalls; one response unblocks it next cycle.
- c_q_ready_i held low 3 cycles → c_q payload unchanged, instr_ready_o=0; then 4 back-to-back accepts at one per cycle.
- Error response rd=7 → err_o=1/err_rd_o=7 one cycle, wb_valid_o stays 0, counter decremented.
- Assert rst_ni low with 2 outstanding and wb_valid_o high → all outputs at reset values asynchronously; stall_o=0 afterward.
